// File: rtl/control_sequencer_pkg.sv
// Shared types for the NSC-8 control sequencer: state encodings, opcodes, control word.
// Optional macro CONTROL_SEQUENCER_SINGLE_STEP_EN adds the STEP_WAIT state encoding.
package control_sequencer_pkg;

    typedef enum logic [2:0] {
        S_FETCH0    = 3'd0,
        S_FETCH1    = 3'd1,
        S_EXEC0     = 3'd2,
        S_EXEC1     = 3'd3,
        S_EXEC2     = 3'd4,
        S_HALT      = 3'd5
`ifdef CONTROL_SEQUENCER_SINGLE_STEP_EN
        ,
        S_STEP_WAIT = 3'd6
`endif
    } state_t;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef struct packed {
        logic pc_out;
        logic mem_out;
        logic ir_out;
        logic a_out;
        logic alu_out;
        logic pc_inc;
        logic pc_load;
        logic mar_load;
        logic ir_load;
        logic mem_write;
        logic load_a;
        logic load_immediate_a;
        logic b_load;
        logic out_load;
        logic alu_sub;
    } ctrl_t;

    // Number of execute microsteps; undefined opcodes behave as one-step NOPs.
    function automatic logic [1:0] exec_steps(input logic [3:0] op);
        case (op)
            OP_LDA, OP_STA: exec_steps = 2'd2;
            OP_ADD, OP_SUB: exec_steps = 2'd3;
            default:        exec_steps = 2'd1;
        endcase
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Control bus between the sequencer (master) and the NSC-8 datapath (slave).
// CONTROL_SEQUENCER_SINGLE_STEP_EN adds the step_mode/step inputs.
interface control_sequencer_if #(
    parameter int OPCODE_W = 4
);
    logic [OPCODE_W-1:0] opcode;
    logic                carry_flag;
    logic                zero_flag;
`ifdef CONTROL_SEQUENCER_SINGLE_STEP_EN
    logic                step_mode;
    logic                step;
`endif
    logic                pc_out;
    logic                mem_out;
    logic                ir_out;
    logic                a_out;
    logic                alu_out;
    logic                pc_inc;
    logic                pc_load;
    logic                mar_load;
    logic                ir_load;
    logic                mem_write;
    logic                load_a;
    logic                load_immediate_a;
    logic                b_load;
    logic                out_load;
    logic                alu_sub;
    logic                halted;
    logic [2:0]          t_state;

    modport master (
        input  opcode, carry_flag, zero_flag,
`ifdef CONTROL_SEQUENCER_SINGLE_STEP_EN
        input  step_mode, step,
`endif
        output pc_out, mem_out, ir_out, a_out, alu_out,
        output pc_inc, pc_load, mar_load, ir_load,
        output mem_write, load_a, load_immediate_a, b_load, out_load, alu_sub,
        output halted, t_state
    );

    modport slave (
        output opcode, carry_flag, zero_flag,
`ifdef CONTROL_SEQUENCER_SINGLE_STEP_EN
        output step_mode, step,
`endif
        input  pc_out, mem_out, ir_out, a_out, alu_out,
        input  pc_inc, pc_load, mar_load, ir_load,
        input  mem_write, load_a, load_immediate_a, b_load, out_load, alu_sub,
        input  halted, t_state
    );

endinterface

// File: rtl/control_sequencer_decoder.sv
// Combinational microcode ROM: (state, opcode, flags) -> one control word per cycle.
module control_decoder
    import control_sequencer_pkg::*;
(
    input  state_t     state,
    input  logic [3:0] opcode,
    input  logic       carry_flag,
    input  logic       zero_flag,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH0: begin
                ctrl.pc_out   = 1'b1;
                ctrl.mar_load = 1'b1;
            end
            S_FETCH1: begin
                ctrl.mem_out = 1'b1;
                ctrl.ir_load = 1'b1;
                ctrl.pc_inc  = 1'b1;
            end
            S_EXEC0: begin
                // Flags only matter here; conditional jumps resolve in this single step.
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        ctrl.ir_out   = 1'b1;
                        ctrl.mar_load = 1'b1;
                    end
                    OP_LDI: begin
                        ctrl.ir_out           = 1'b1;
                        ctrl.load_immediate_a = 1'b1;
                    end
                    OP_JMP: begin
                        ctrl.ir_out  = 1'b1;
                        ctrl.pc_load = 1'b1;
                    end
                    OP_JC: begin
                        ctrl.ir_out  = 1'b1;
                        ctrl.pc_load = carry_flag;
                    end
                    OP_JZ: begin
                        ctrl.ir_out  = 1'b1;
                        ctrl.pc_load = zero_flag;
                    end
                    OP_OUT: begin
                        ctrl.a_out    = 1'b1;
                        ctrl.out_load = 1'b1;
                    end
                    default: ctrl = '0;
                endcase
            end
            S_EXEC1: begin
                case (opcode)
                    OP_LDA: begin
                        ctrl.mem_out = 1'b1;
                        ctrl.load_a  = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        ctrl.mem_out = 1'b1;
                        ctrl.b_load  = 1'b1;
                        ctrl.alu_sub = (opcode == OP_SUB);
                    end
                    OP_STA: begin
                        ctrl.a_out     = 1'b1;
                        ctrl.mem_write = 1'b1;
                    end
                    default: ctrl = '0;
                endcase
            end
            S_EXEC2: begin
                if (opcode == OP_ADD || opcode == OP_SUB) begin
                    ctrl.alu_out = 1'b1;
                    ctrl.load_a  = 1'b1;
                    ctrl.alu_sub = (opcode == OP_SUB);
                end
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// NSC-8 fetch/decode/execute sequencer: state register, next-state logic, gated outputs.
// Optional single-step mode is enabled with `define CONTROL_SEQUENCER_SINGLE_STEP_EN.
module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter int X        = 8,
    parameter int OPCODE_W = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    control_sequencer_if.master  bus
);

    if ((X % 2) != 0 || OPCODE_W != 4) begin : g_param_check
        $error("control_sequencer: X must be even and OPCODE_W must be 4");
    end

    state_t state;
    state_t state_next;
    state_t boundary;
    ctrl_t  ctrl;
    ctrl_t  ctrl_gated;
    logic [1:0] steps;

    assign steps = exec_steps(bus.opcode);

    // Where the sequencer lands between instructions (and after reset).
`ifdef CONTROL_SEQUENCER_SINGLE_STEP_EN
    assign boundary = bus.step_mode ? S_STEP_WAIT : S_FETCH0;
`else
    assign boundary = S_FETCH0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= boundary;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_FETCH0: state_next = S_FETCH1;
            S_FETCH1: state_next = S_EXEC0;
            S_EXEC0: begin
                if (bus.opcode == OP_HLT) begin
                    state_next = S_HALT;
                end else if (steps == 2'd1) begin
                    state_next = boundary;
                end else begin
                    state_next = S_EXEC1;
                end
            end
            S_EXEC1:  state_next = (steps == 2'd2) ? boundary : S_EXEC2;
            S_EXEC2:  state_next = boundary;
            S_HALT:   state_next = S_HALT;
`ifdef CONTROL_SEQUENCER_SINGLE_STEP_EN
            S_STEP_WAIT: state_next = bus.step ? S_FETCH0 : S_STEP_WAIT;
`endif
            default:  state_next = S_FETCH0;
        endcase
    end

    control_decoder u_decoder (
        .state      (state),
        .opcode     (bus.opcode),
        .carry_flag (bus.carry_flag),
        .zero_flag  (bus.zero_flag),
        .ctrl       (ctrl)
    );

    // While reset is asserted nothing may write, even mid-instruction.
    always_comb begin
        ctrl_gated           = reset_n ? ctrl : '0;
        bus.pc_out           = ctrl_gated.pc_out;
        bus.mem_out          = ctrl_gated.mem_out;
        bus.ir_out           = ctrl_gated.ir_out;
        bus.a_out            = ctrl_gated.a_out;
        bus.alu_out          = ctrl_gated.alu_out;
        bus.pc_inc           = ctrl_gated.pc_inc;
        bus.pc_load          = ctrl_gated.pc_load;
        bus.mar_load         = ctrl_gated.mar_load;
        bus.ir_load          = ctrl_gated.ir_load;
        bus.mem_write        = ctrl_gated.mem_write;
        bus.load_a           = ctrl_gated.load_a;
        bus.load_immediate_a = ctrl_gated.load_immediate_a;
        bus.b_load           = ctrl_gated.b_load;
        bus.out_load         = ctrl_gated.out_load;
        bus.alu_sub          = ctrl_gated.alu_sub;
        bus.halted           = reset_n && (state == S_HALT);
        bus.t_state          = state;
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: stimulus pushes per-cycle expected control words,
// a negedge monitor pops and compares them and checks the bus invariants every cycle.
module tb_control_sequencer;

    localparam logic [14:0] PC_OUT    = 15'h0001;
    localparam logic [14:0] MEM_OUT   = 15'h0002;
    localparam logic [14:0] IR_OUT    = 15'h0004;
    localparam logic [14:0] A_OUT     = 15'h0008;
    localparam logic [14:0] ALU_OUT   = 15'h0010;
    localparam logic [14:0] PC_INC    = 15'h0020;
    localparam logic [14:0] PC_LOAD   = 15'h0040;
    localparam logic [14:0] MAR_LOAD  = 15'h0080;
    localparam logic [14:0] IR_LOAD   = 15'h0100;
    localparam logic [14:0] MEM_WRITE = 15'h0200;
    localparam logic [14:0] LOAD_A    = 15'h0400;
    localparam logic [14:0] LOAD_IMM  = 15'h0800;
    localparam logic [14:0] B_LOAD    = 15'h1000;
    localparam logic [14:0] OUT_LOAD  = 15'h2000;
    localparam logic [14:0] ALU_SUB   = 15'h4000;

    typedef struct {
        logic [14:0] ctrl;
        logic        halted;
        logic [2:0]  st;
        bit          chk_st;
        string       name;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic clk = 1'b0;
    logic reset_n;
    logic [14:0] word;

    control_sequencer_if #(.OPCODE_W(4)) bus ();

    control_sequencer #(.X(8), .OPCODE_W(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    always #5 clk = ~clk;

    assign word = {bus.alu_sub, bus.out_load, bus.b_load, bus.load_immediate_a, bus.load_a,
                   bus.mem_write, bus.ir_load, bus.mar_load, bus.pc_load, bus.pc_inc,
                   bus.alu_out, bus.a_out, bus.ir_out, bus.mem_out, bus.pc_out};

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    // Monitor: invariants every cycle, scoreboard entry when one is pending.
    always @(negedge clk) begin
        exp_t e;
        check("bus_driver_onehot", 32'($countones(word[4:0]) <= 1), 32'd1);
        check("load_a_vs_imm", 32'(bus.load_a & bus.load_immediate_a), 32'd0);
        check("pc_inc_vs_load", 32'(bus.pc_inc & bus.pc_load), 32'd0);
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            check({e.name, " ctrl"}, 32'(word), 32'(e.ctrl));
            check({e.name, " halted"}, 32'(bus.halted), 32'(e.halted));
            if (e.chk_st) check({e.name, " t_state"}, 32'(bus.t_state), 32'(e.st));
        end
    end

    task automatic cyc(input logic [14:0] c, input logic h, input logic [2:0] st,
                       input bit chk, input string nm);
        exp_t e;
        e.ctrl = c; e.halted = h; e.st = st; e.chk_st = chk; e.name = nm;
        sbq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Flags are driven inverted outside EXEC0 so only the EXEC0 value may matter.
    task automatic run_instr(input logic [3:0] op, input logic c, input logic z, input string nm);
        logic [14:0] e0, e1, e2;
        int n;
        n = 1; e0 = '0; e1 = '0; e2 = '0;
        case (op)
            4'h1: begin n = 2; e0 = IR_OUT | MAR_LOAD; e1 = MEM_OUT | LOAD_A; end
            4'h2: begin n = 3; e0 = IR_OUT | MAR_LOAD; e1 = MEM_OUT | B_LOAD;
                        e2 = ALU_OUT | LOAD_A; end
            4'h3: begin n = 3; e0 = IR_OUT | MAR_LOAD; e1 = MEM_OUT | B_LOAD | ALU_SUB;
                        e2 = ALU_OUT | LOAD_A | ALU_SUB; end
            4'h4: begin n = 2; e0 = IR_OUT | MAR_LOAD; e1 = A_OUT | MEM_WRITE; end
            4'h5: e0 = IR_OUT | LOAD_IMM;
            4'h6: e0 = IR_OUT | PC_LOAD;
            4'h7: e0 = IR_OUT | (c ? PC_LOAD : 15'h0);
            4'h8: e0 = IR_OUT | (z ? PC_LOAD : 15'h0);
            4'hE: e0 = A_OUT | OUT_LOAD;
            default: e0 = '0;
        endcase
        bus.opcode = ~op; bus.carry_flag = ~c; bus.zero_flag = ~z;
        cyc(PC_OUT | MAR_LOAD, 1'b0, 3'd0, 1'b1, {nm, " F0"});
        cyc(MEM_OUT | IR_LOAD | PC_INC, 1'b0, 3'd1, 1'b1, {nm, " F1"});
        bus.opcode = op; bus.carry_flag = c; bus.zero_flag = z;
        cyc(e0, 1'b0, 3'd2, 1'b1, {nm, " E0"});
        bus.carry_flag = ~c; bus.zero_flag = ~z;
        if (n > 1) cyc(e1, 1'b0, 3'd3, 1'b1, {nm, " E1"});
        if (n > 2) cyc(e2, 1'b0, 3'd4, 1'b1, {nm, " E2"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        bus.opcode = 4'h0;
        bus.carry_flag = 1'b0;
        bus.zero_flag = 1'b0;
`ifdef CONTROL_SEQUENCER_SINGLE_STEP_EN
        bus.step_mode = 1'b0;
        bus.step = 1'b0;
`endif
        @(posedge clk);
        #1;
        // Reset held for two cycles: everything quiet, state parked at FETCH0.
        bus.opcode = 4'h2;
        cyc('0, 1'b0, 3'd0, 1'b1, "reset0");
        cyc('0, 1'b0, 3'd0, 1'b1, "reset1");
        reset_n = 1'b1;

        run_instr(4'h5, 1'b0, 1'b0, "ldi_5a");
        run_instr(4'h2, 1'b1, 1'b1, "add");
        run_instr(4'h3, 1'b0, 1'b0, "sub");
        run_instr(4'h1, 1'b0, 1'b1, "lda");
        run_instr(4'h4, 1'b1, 1'b0, "sta");
        run_instr(4'h6, 1'b0, 1'b0, "jmp");
        run_instr(4'h7, 1'b0, 1'b1, "jc_nc");
        run_instr(4'h7, 1'b1, 1'b0, "jc_c");
        run_instr(4'h8, 1'b1, 1'b0, "jz_nz");
        run_instr(4'h8, 1'b0, 1'b1, "jz_z");
        run_instr(4'hE, 1'b0, 1'b0, "out");
        run_instr(4'h0, 1'b1, 1'b1, "nop");
        run_instr(4'hB, 1'b0, 1'b0, "undef_b");

        // Reset during EXEC1 of ADD: b_load suppressed, restart at FETCH0.
        bus.opcode = 4'hD;
        cyc(PC_OUT | MAR_LOAD, 1'b0, 3'd0, 1'b1, "add_abort F0");
        cyc(MEM_OUT | IR_LOAD | PC_INC, 1'b0, 3'd1, 1'b1, "add_abort F1");
        bus.opcode = 4'h2;
        cyc(IR_OUT | MAR_LOAD, 1'b0, 3'd2, 1'b1, "add_abort E0");
        reset_n = 1'b0;
        cyc('0, 1'b0, 3'd3, 1'b1, "add_abort E1");
        reset_n = 1'b1;
        run_instr(4'h5, 1'b0, 1'b0, "after_abort");

        for (int i = 0; i < 40; i++) begin
            run_instr(4'($urandom_range(0, 14)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), $sformatf("rand%0d", i));
        end

        run_instr(4'hF, 1'b0, 1'b0, "hlt");
        for (int i = 0; i < 20; i++) begin
            bus.opcode = 4'($urandom_range(0, 15));
            bus.carry_flag = 1'($urandom_range(0, 1));
            cyc('0, 1'b1, 3'd5, 1'b1, "halt");
        end
        reset_n = 1'b0;
        cyc('0, 1'b0, 3'd5, 1'b1, "halt_reset");
        reset_n = 1'b1;
        run_instr(4'h1, 1'b0, 1'b0, "post_halt");

`ifdef CONTROL_SEQUENCER_SINGLE_STEP_EN
        bus.step_mode = 1'b1;
        bus.step = 1'b0;
        reset_n = 1'b0;
        cyc('0, 1'b0, 3'd0, 1'b0, "step_reset");
        reset_n = 1'b1;
        cyc('0, 1'b0, 3'd6, 1'b1, "step_wait0");
        cyc('0, 1'b0, 3'd6, 1'b1, "step_wait1");
        bus.step = 1'b1;
        cyc('0, 1'b0, 3'd6, 1'b1, "step_pulse");
        bus.step = 1'b0;
        run_instr(4'h2, 1'b0, 1'b0, "step_add");
        cyc('0, 1'b0, 3'd6, 1'b1, "step_wait2");
        bus.step = 1'b1;
        cyc('0, 1'b0, 3'd6, 1'b1, "step_pulse2");
        bus.step_mode = 1'b0;
        bus.step = 1'b0;
        run_instr(4'h5, 1'b0, 1'b0, "free_ldi");
        run_instr(4'h0, 1'b0, 1'b0, "free_nop");
`endif

        @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
